anim_scene_ctrl: RTL and testbench

- Parametrised per-frame animation and scene sequencer, the successor to the hard-wired angle/model logic in the display top level.
- Generates NUM_AXES rotation angles with per-axis step, speed shift and direction, and a model index that auto-cycles on a frame timer or advances manually.
- Provides pause and single-step control from user inputs.
- Outputs feed the rotation engines and scene_objects model_select; updates are paced by the vga_timing frame pulse.

---
 rtl/anim_scene_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_anim_scene_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/anim_scene_ctrl.sv
// anim_scene_ctrl: per-frame animation and scene sequencer.
//
// Produces NUM_AXES wrapping rotation angles (per-axis base step, shared speed shift and
// direction) and a model index that either auto-cycles every HOLD_FRAMES frames or advances
// on user request. User inputs are synchronised and edge-detected; pause and single-step are
// handled by a small RUN/PAUSED/STEP state machine. Motion is paced by the frame pulse.
//
// Optional build macro ANIM_FRAME_DIV_EN: adds parameter FRAME_DIV so that only every
// FRAME_DIV-th frame moves the angles and the model timer (single step bypasses it).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame        one-cycle start-of-frame pulse
//   ui_in        raw async user inputs: [0] pause toggle, [1] next model, [2] reverse,
//                [3] speed up, [4] speed down, [5] zero angles, [6] single step,
//                [7] auto-cycle enable (level)
//   angles       packed signed angles, axis i at [i*ANGLE_W +: ANGLE_W]
//   model_select current model index
//   model_change one-cycle pulse when model_select changes
//   paused       high in PAUSED state
//   speed_shift  current speed shift
module anim_scene_ctrl #(
    parameter int unsigned                   ANGLE_W     = 16,
    parameter int unsigned                   NUM_AXES    = 3,
    parameter logic [NUM_AXES*ANGLE_W-1:0]   AXIS_STEP   = {16'd7, 16'd7, 16'd7},
    parameter int unsigned                   NUM_MODELS  = 3,
    parameter int unsigned                   MODEL_INIT  = 2,
    parameter int unsigned                   HOLD_FRAMES = 180,
    parameter int unsigned                   MAX_SHIFT   = 3,
`ifdef ANIM_FRAME_DIV_EN
    parameter int unsigned                   FRAME_DIV   = 2,
`endif
    localparam int unsigned MODEL_W = (NUM_MODELS > 1) ? $clog2(NUM_MODELS) : 1,
    localparam int unsigned SHIFT_W = (MAX_SHIFT > 0) ? $clog2(MAX_SHIFT + 1) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame,
    input  logic [7:0]                         ui_in,
    output logic signed [NUM_AXES*ANGLE_W-1:0] angles,
    output logic [MODEL_W-1:0]                 model_select,
    output logic                               model_change,
    output logic                               paused,
    output logic [SHIFT_W-1:0]                 speed_shift
);

    localparam int unsigned TIMER_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {StRun, StPaused, StStep} state_e;

    // Synchroniser, edge detect and registered one-cycle events
    logic [7:0] ui_meta_q, ui_sync_q;
    logic [6:0] ui_prev_q, ev_q;

    logic ev_pause, ev_next, ev_rev, ev_up, ev_down, ev_zero, ev_step, auto_en;
    assign ev_pause = ev_q[0];
    assign ev_next  = ev_q[1];
    assign ev_rev   = ev_q[2];
    assign ev_up    = ev_q[3];
    assign ev_down  = ev_q[4];
    assign ev_zero  = ev_q[5];
    assign ev_step  = ev_q[6];
    assign auto_en  = ui_sync_q[7];

    state_e                             state_q, state_d;
    logic [NUM_AXES-1:0][ANGLE_W-1:0]   angle_q, angle_d, inc;
    logic                               dir_q, dir_d;   // 1 = reversed
    logic [SHIFT_W-1:0]                 shift_q, shift_d;
    logic [TIMER_W-1:0]                 timer_q, timer_d;
    logic [MODEL_W-1:0]                 model_q, model_d;
    logic                               model_change_q;

    logic run_tick, step_tick, upd, timer_count, expire, advance;

`ifdef ANIM_FRAME_DIV_EN
    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    logic [DIV_W-1:0] div_q, div_d;
    logic             div_hit;

    assign div_hit   = (div_q == DIV_W'(FRAME_DIV - 1));
    assign run_tick  = frame && div_hit;
    assign step_tick = frame;   // a single step never waits on the divider

    always_comb begin
        div_d = div_q;
        if (state_q == StPaused && ev_step) begin
            div_d = '0;
        end else if (frame && (state_q == StRun || state_q == StStep)) begin
            div_d = div_hit ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end
`else
    assign run_tick  = frame;
    assign step_tick = frame;
`endif

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (ev_pause) state_d = StPaused;
            StPaused: begin
                if (ev_pause)     state_d = StRun;
                else if (ev_step) state_d = StStep;
            end
            StStep: begin
                if (ev_pause)  state_d = StRun;      // pending step discarded
                else if (frame) state_d = StPaused;
            end
            default: state_d = StRun;
        endcase
    end

    assign upd = (state_q == StRun && run_tick) ||
                 (state_q == StStep && step_tick && !ev_pause);

    // Angle, direction and speed
    always_comb begin
        angle_d = angle_q;
        for (int i = 0; i < NUM_AXES; i++) begin
            inc[i] = AXIS_STEP[i*ANGLE_W +: ANGLE_W] << shift_q;
        end
        if (ev_zero) begin
            angle_d = '0;
        end else if (upd) begin
            for (int i = 0; i < NUM_AXES; i++) begin
                angle_d[i] = dir_q ? angle_q[i] - inc[i] : angle_q[i] + inc[i];
            end
        end
    end

    assign dir_d = dir_q ^ ev_rev;

    always_comb begin
        shift_d = shift_q;
        if (ev_up && !ev_down && shift_q != SHIFT_W'(MAX_SHIFT)) begin
            shift_d = shift_q + 1'b1;
        end else if (ev_down && !ev_up && shift_q != '0) begin
            shift_d = shift_q - 1'b1;
        end
    end

    // Model timer and selection; a manual advance and an expiry together advance once
    assign timer_count = (state_q == StRun) && auto_en && run_tick;
    assign expire      = timer_count && (timer_q == TIMER_W'(HOLD_FRAMES - 1));
    assign advance     = ev_next || expire;

    always_comb begin
        timer_d = timer_q;
        model_d = model_q;
        if (advance) begin
            timer_d = '0;
            model_d = (model_q == MODEL_W'(NUM_MODELS - 1)) ? '0 : model_q + 1'b1;
        end else if (timer_count) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_meta_q      <= '0;
            ui_sync_q      <= '0;
            ui_prev_q      <= '0;
            ev_q           <= '0;
            state_q        <= StRun;
            angle_q        <= '0;
            dir_q          <= 1'b0;
            shift_q        <= '0;
            timer_q        <= '0;
            model_q        <= MODEL_W'(MODEL_INIT);
            model_change_q <= 1'b0;
        end else begin
            ui_meta_q      <= ui_in;
            ui_sync_q      <= ui_meta_q;
            ui_prev_q      <= ui_sync_q[6:0];
            ev_q           <= ui_sync_q[6:0] & ~ui_prev_q;
            state_q        <= state_d;
            angle_q        <= angle_d;
            dir_q          <= dir_d;
            shift_q        <= shift_d;
            timer_q        <= timer_d;
            model_q        <= model_d;
            model_change_q <= (model_d != model_q);
        end
    end

    assign angles       = angle_q;
    assign model_select = model_q;
    assign model_change = model_change_q;
    assign paused       = (state_q == StPaused);
    assign speed_shift  = shift_q;

endmodule

// File: tb/tb_anim_scene_ctrl.sv
// Scoreboard bench for anim_scene_ctrl (HOLD_FRAMES=4, other parameters default).
// Stimulus pushes expected snapshots / model indices; two monitors pop and compare.
module tb_anim_scene_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               frame;
    logic [7:0]         ui_in;
    logic signed [47:0] angles;
    logic [1:0]         model_select;
    logic               model_change;
    logic               paused;
    logic [1:0]         speed_shift;

    anim_scene_ctrl #(
        .HOLD_FRAMES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame       (frame),
        .ui_in       (ui_in),
        .angles      (angles),
        .model_select(model_select),
        .model_change(model_change),
        .paused      (paused),
        .speed_shift (speed_shift)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [15:0] ang;
        logic [1:0]  model;
        logic        paused;
        logic [1:0]  shift;
    } snap_t;

    snap_t      exp_q[$];
    logic [1:0] model_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Snapshot monitor
    snap_t s;
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s/angle%0d", s.name, i), 64'(angles[i*16 +: 16]), 64'(s.ang));
            end
            check({s.name, "/model_select"}, 64'(model_select), 64'(s.model));
            check({s.name, "/paused"}, 64'(paused), 64'(s.paused));
            check({s.name, "/speed_shift"}, 64'(speed_shift), 64'(s.shift));
            check({s.name, "/model_change"}, 64'(model_change), 64'd0);
        end
    end

    // Model-change monitor: every pulse must match the next expected model index
    logic [1:0] m;
    always @(negedge clk) begin
        if (rst_n && model_change) begin
            if (model_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL model_change: unexpected pulse with model_select=%0d, required none",
                         model_select);
            end else begin
                m = model_q.pop_front();
                check("model_change/model_select", 64'(model_select), 64'(m));
            end
        end
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame = 1'b1;
            step_clk(1);
            frame = 1'b0;
            step_clk(1);
        end
    endtask

    task automatic pulse(input int b);
        ui_in[b] = 1'b1;
        step_clk(2);
        ui_in[b] = 1'b0;
        step_clk(5);
    endtask

    // Raise ui_in[b] so its event lands on the same edge as a frame
    task automatic coincide(input int b);
        ui_in[b] = 1'b1;
        repeat (3) @(posedge clk);
        #1 frame = 1'b1;
        step_clk(1);
        frame    = 1'b0;
        ui_in[b] = 1'b0;
        step_clk(5);
    endtask

    task automatic expect_snap(input string name, input logic [15:0] a, input logic [1:0] md,
                               input logic p, input logic [1:0] sh);
        snap_t e;
        e.name = name; e.ang = a; e.model = md; e.paused = p; e.shift = sh;
        exp_q.push_back(e);
        step_clk(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        frame = 1'b0;
        ui_in = 8'h00;
        step_clk(3);
        expect_snap("reset", 16'd0, 2'd2, 1'b0, 2'd0);
        rst_n = 1'b1;
        step_clk(2);

        frames(5);
        expect_snap("run5", 16'd35, 2'd2, 1'b0, 2'd0);

        pulse(3); pulse(3);
        expect_snap("shift2", 16'd35, 2'd2, 1'b0, 2'd2);
        frames(1);
        expect_snap("frame_shift2", 16'd63, 2'd2, 1'b0, 2'd2);
        repeat (3) pulse(3);
        expect_snap("shift_sat_hi", 16'd63, 2'd2, 1'b0, 2'd3);
        repeat (4) pulse(4);
        expect_snap("shift_sat_lo", 16'd63, 2'd2, 1'b0, 2'd0);

        // Auto cycling with a pause in the middle
        ui_in[7] = 1'b1;
        step_clk(4);
        model_q.push_back(2'd0);
        frames(4);
        expect_snap("auto_wrap", 16'd91, 2'd0, 1'b0, 2'd0);
        frames(2);
        pulse(0);
        expect_snap("auto_paused", 16'd105, 2'd0, 1'b1, 2'd0);
        frames(3);
        pulse(0);
        frames(1);
        expect_snap("timer_frozen", 16'd112, 2'd0, 1'b0, 2'd0);
        model_q.push_back(2'd1);
        frames(1);
        expect_snap("auto_next", 16'd119, 2'd1, 1'b0, 2'd0);
        ui_in[7] = 1'b0;
        step_clk(4);

        // Single step
        pulse(0);
        expect_snap("pause", 16'd119, 2'd1, 1'b1, 2'd0);
        pulse(6);
        frames(3);
        expect_snap("single_step", 16'd126, 2'd1, 1'b1, 2'd0);
        pulse(5);
        expect_snap("zero_paused", 16'd0, 2'd1, 1'b1, 2'd0);

        // Reach angle 3: 2340*56 + 5*7 = 131075 = 2*65536 + 3
        pulse(0);
        repeat (3) pulse(3);
        frames(2340);
        repeat (3) pulse(4);
        frames(5);
        expect_snap("angle_three", 16'd3, 2'd1, 1'b0, 2'd0);
        pulse(2);
        frames(1);
        expect_snap("reverse_wrap", 16'hFFFC, 2'd1, 1'b0, 2'd0);
        coincide(5);
        expect_snap("zero_on_frame", 16'd0, 2'd1, 1'b0, 2'd0);

        // Next-model event on the expiry frame
        ui_in[7] = 1'b1;
        step_clk(4);
        frames(3);
        expect_snap("timer_at_3", 16'hFFEB, 2'd1, 1'b0, 2'd0);
        model_q.push_back(2'd2);
        coincide(1);
        expect_snap("next_on_expiry", 16'hFFE4, 2'd2, 1'b0, 2'd0);
        frames(3);
        expect_snap("timer_cleared", 16'hFFCF, 2'd2, 1'b0, 2'd0);
        model_q.push_back(2'd0);
        frames(1);
        expect_snap("expiry_after_next", 16'hFFC8, 2'd0, 1'b0, 2'd0);
        ui_in[7] = 1'b0;
        step_clk(4);

        // Reset while a step is pending
        pulse(0);
        pulse(6);
        rst_n = 1'b0;
        step_clk(2);
        expect_snap("reset_mid_step", 16'd0, 2'd2, 1'b0, 2'd0);
        rst_n = 1'b1;
        step_clk(2);
        pulse(0);
        frames(1);
        expect_snap("no_step_after_reset", 16'd0, 2'd2, 1'b1, 2'd0);

        step_clk(4);
        check("model_queue_drained", 64'(model_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
